// File: rtl/daq_frame_builder_if.sv
// Sample-FIFO read side plus slave-FIFO host write side of the frame builder.
interface daq_frame_builder_if;
  logic        fifo_empty_i;
  logic        fifo_rdreq_o;
  logic [15:0] fifo_q_i;
  logic [15:0] pkt_data_o;
  logic        pkt_wr_o;
  logic        pkt_full_i;
  logic        pkt_end_o;

  modport master (
    input  fifo_empty_i, fifo_q_i, pkt_full_i,
    output fifo_rdreq_o, pkt_data_o, pkt_wr_o, pkt_end_o
  );

  modport slave (
    output fifo_empty_i, fifo_q_i, pkt_full_i,
    input  fifo_rdreq_o, pkt_data_o, pkt_wr_o, pkt_end_o
  );
endinterface

// File: rtl/daq_frame_builder.sv
// Drains the sample FIFO and emits SYNC, sequence, ADCCOUNT samples and a
// 16-bit checksum per frame to a back-pressured host FIFO.
module daq_frame_builder #(
  parameter int unsigned ADCCOUNT  = 8,
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter logic [15:0] SEQ_INIT  = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  daq_frame_builder_if.master  bus,
  output logic [15:0]          frame_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, FETCH, WAITQ, PUSH, CSUM} state_t;

  localparam logic [7:0] LAST = 8'(ADCCOUNT - 1);

  state_t      state;
  logic [15:0] seq;
  logic [15:0] csum;
  logic [15:0] sample;
  logic [7:0]  count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      seq    <= SEQ_INIT;
      csum   <= '0;
      sample <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (en_i && !bus.fifo_empty_i) begin
          state <= SYNC;
          count <= '0;
          csum  <= '0;
        end
        SYNC: if (!bus.pkt_full_i) state <= SEQ;
        SEQ: if (!bus.pkt_full_i) begin
          csum  <= seq;
          state <= FETCH;
        end
        FETCH: if (!bus.fifo_empty_i) state <= WAITQ;
        // Non-show-ahead FIFO: data for the read issued in FETCH lands here.
        WAITQ: begin
          sample <= bus.fifo_q_i;
          csum   <= csum + bus.fifo_q_i;
          state  <= PUSH;
        end
        PUSH: if (!bus.pkt_full_i) begin
          count <= count + 8'd1;
          state <= (count == LAST) ? CSUM : FETCH;
        end
        CSUM: if (!bus.pkt_full_i) begin
          seq   <= seq + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the live full/empty flags so a stall never drops a word.
  always_comb begin
    bus.pkt_data_o   = '0;
    bus.pkt_wr_o     = 1'b0;
    bus.pkt_end_o    = 1'b0;
    bus.fifo_rdreq_o = 1'b0;
    case (state)
      SYNC: begin
        bus.pkt_data_o = SYNC_WORD;
        bus.pkt_wr_o   = !bus.pkt_full_i;
      end
      SEQ: begin
        bus.pkt_data_o = seq;
        bus.pkt_wr_o   = !bus.pkt_full_i;
      end
      FETCH: bus.fifo_rdreq_o = !bus.fifo_empty_i;
      PUSH: begin
        bus.pkt_data_o = sample;
        bus.pkt_wr_o   = !bus.pkt_full_i;
      end
      CSUM: begin
        bus.pkt_data_o = csum;
        bus.pkt_wr_o   = !bus.pkt_full_i;
        bus.pkt_end_o  = !bus.pkt_full_i;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign frame_cnt_o = seq;

endmodule

// File: doc/daq_frame_builder.md
Name: daq_frame_builder

Overview:
- Downstream stage of the DAQ packetizer; drains its 16-bit sample FIFO (read side) and wraps each group of ADCCOUNT samples into a framed packet.
- Frame = SYNC_WORD, sequence number, ADCCOUNT samples, 16-bit checksum.
- Frames go to a slave-FIFO style host interface (USB bridge) with full back-pressure.
- Single clock domain; the FIFO read clock is tied to clk_i at the top level.

Parameters:
- ADCCOUNT, 8, samples per frame; legal range 1..255.
- SYNC_WORD, 16'hA55A, first word of every frame.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  frame start enable; sampled only in IDLE.
- fifo_empty_i  input  1  sample FIFO empty flag.
- fifo_rdreq_o  output  1  FIFO read request; one word per cycle high.
- fifo_q_i  input  16  FIFO read data; valid the cycle after fifo_rdreq_o is high (non-show-ahead).
- pkt_data_o  output  16  host data word.
- pkt_wr_o  output  1  host write strobe; a word transfers on the clock edge where pkt_wr_o=1.
- pkt_full_i  input  1  host FIFO full; no transfer is allowed while it is high.
- pkt_end_o  output  1  high with the last (checksum) word of a frame.
- frame_cnt_o  output  16  sequence number of the next frame to be emitted.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - state=IDLE; seq=0; sample count=0; checksum=0; sample register=0.
  - All outputs 0: fifo_rdreq_o, pkt_wr_o, pkt_end_o, busy_o, pkt_data_o=0, frame_cnt_o=0.
  - Reset mid-frame truncates the frame with no further words; the host resynchronises on SYNC_WORD.
- States: IDLE, SYNC, SEQ, FETCH, WAITQ, PUSH, CSUM.
- State transitions and outputs:
  - IDLE: if en_i=1 and fifo_empty_i=0, go to SYNC; clear sample count and checksum.
  - SYNC: pkt_data_o=SYNC_WORD; pkt_wr_o=!pkt_full_i. On transfer, go to SEQ; otherwise hold.
  - SEQ: pkt_data_o=seq; pkt_wr_o=!pkt_full_i. On transfer, checksum<=seq and go to FETCH.
  - FETCH: fifo_rdreq_o=!fifo_empty_i. If not empty, go to WAITQ; otherwise hold (waits indefinitely).
  - WAITQ: sample register<=fifo_q_i; checksum<=checksum+fifo_q_i (mod 2^16); go to PUSH.
  - PUSH: pkt_data_o=sample register; pkt_wr_o=!pkt_full_i. On transfer, count+1; go to CSUM if count reaches ADCCOUNT, else FETCH.
  - CSUM: pkt_data_o=checksum; pkt_wr_o=!pkt_full_i; pkt_end_o=pkt_wr_o. On transfer, seq<=seq+1 (wraps 0xFFFF->0x0000) and go to IDLE.
- Output timing:
  - pkt_wr_o, pkt_data_o, pkt_end_o and fifo_rdreq_o are combinational from registered state and the live full/empty inputs.
  - No other logic drives them.
- Checksum: 16-bit modulo sum of the sequence word and all ADCCOUNT samples; SYNC_WORD is excluded; carries are discarded.
- FIFO reads: exactly one FIFO read per sample, i.e. exactly ADCCOUNT reads per frame.
  - fifo_rdreq_o is never high while fifo_empty_i=1.
  - fifo_rdreq_o is never high outside FETCH.
- Back-pressure: while pkt_full_i=1, the state, data and counters are frozen. The word is presented again unchanged once full drops.
- en_i deasserted mid-frame: the frame completes normally; the change takes effect in IDLE.
- Throughput, no stalls: 1 (IDLE) + 2 + 3*ADCCOUNT + 1 cycles per frame; 28 cycles for ADCCOUNT=8.
  - First SYNC transfer occurs 1 cycle after IDLE sees en_i=1 and !fifo_empty_i.
- frame_cnt_o = seq; it updates on the clock edge of the checksum transfer.

Test Plan:
- Basic frame: reset, FIFO preloaded with 0x0001..0x0008, en_i=1, pkt_full_i=0.
  - Host sees A55A, 0000, 0001..0008, 0024.
  - pkt_end_o high only on 0x0024; exactly 8 fifo_rdreq_o pulses; frame_cnt_o=1; back in IDLE after 28 cycles.
- Checksum wrap: second frame of 8 x 0xFFFF.
  - Words: A55A, 0001, 8 x FFFF, FFF9; frame_cnt_o=2.
- Back-pressure: hold pkt_full_i=1 for 5 cycles during SEQ and again during the 4th sample's PUSH.
  - pkt_wr_o=0 and pkt_data_o stable throughout each stall; frame content identical to the basic frame; total latency +10 cycles.
- Underflow: FIFO holds 3 samples, the rest arrive 20 cycles later.
  - Block waits in FETCH with fifo_rdreq_o=0 and busy_o=1; never reads while empty; the frame then completes with the correct checksum.
- Enable and reset mid-frame:
  - Drop en_i after the 2nd sample: the frame completes, then the block stays in IDLE with FIFO non-empty.
  - Assert reset_n_i=0 after the 5th sample (asynchronous, between edges): all outputs 0 immediately; the next frame after release starts with A55A, 0000.
- Sequence wrap: force 65536 frames (or preload seq via a bench backdoor to 0xFFFF).
  - Frame with seq 0xFFFF is followed by seq 0x0000; frame_cnt_o wraps to 0.
